team_08_game_controller: RTL

- Game sequencer for the dino runner; owns the top-level game state (`state_t`: IDLE/RUN/OVER/WIN) and all moving-object geometry.
- Drives the rectangle generator's `state`, `dinoY`, `cactusX`, `x_dist`, `cactusH1` and `cactusH2` inputs.
- Advances physics once per frame tick; handles jump, obstacle scroll/respawn, collision detection and scoring.

---
 rtl/team_08_game_controller_pkg.sv | 53 +++++
 rtl/team_08_game_controller_lfsr8.sv | 24 ++
 rtl/team_08_game_controller.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/team_08_game_controller_pkg.sv
// rtl/team_08_game_controller_pkg.sv - shared game state, screen geometry and frame-state record
package team_08_game_controller_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2,
    WIN  = 2'd3
  } state_t;

  localparam int X_END    = 320;
  localparam int GROUND_Y = 101;
  localparam int DINO_X_L = 280;
  localparam int DINO_X_R = 300;
  localparam int DINO_H   = 38;
  localparam int CACTUS_W = 20;

  // Everything that moves or is scored, kept together so a restart is one assignment.
  typedef struct packed {
    logic [7:0] dino_y;
    logic [7:0] vel;       // two's complement, positive is upward
    logic       air;
    logic [8:0] cactus_x;
    logic [8:0] x_dist;
    logic [7:0] h1;
    logic [7:0] h2;
    logic [7:0] score;
  } geom_t;

  localparam geom_t GEOM_RST = '{
    dino_y:   8'(GROUND_Y),
    vel:      8'd0,
    air:      1'b0,
    cactus_x: 9'd0,
    x_dist:   9'd112,
    h1:       8'd30,
    h2:       8'd40,
    score:    8'd0
  };

  // Box overlap of the dino with one cactus whose left edge is c and height h.
  // The y axis grows upward from the ground line, so the cactus spans GROUND_Y..GROUND_Y+h.
  function automatic logic cactus_hit(input logic [9:0] c, input logic [7:0] h,
                                      input logic [7:0] dino_y);
    logic [9:0] top;
    logic [9:0] dy;
    top = 10'(GROUND_Y) + {2'b00, h};
    dy  = {2'b00, dino_y};
    return (c + 10'(CACTUS_W) >= 10'(DINO_X_L)) && (c <= 10'(DINO_X_R)) &&
           (dy <= top) && (dy + 10'(DINO_H) >= 10'(GROUND_Y));
  endfunction

endpackage

// File: rtl/team_08_game_controller_lfsr8.sv
// rtl/team_08_game_controller_lfsr8.sv - 8-bit Fibonacci LFSR, taps 8,6,5,4
module team_08_lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  output logic [7:0] q_o
);

  logic [7:0] lfsr_q;

  // Shift left, feeding back the XOR of tap bits 8,6,5,4 into bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else if (en_i) begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign q_o = lfsr_q;

endmodule

// File: rtl/team_08_game_controller.sv
// rtl/team_08_game_controller.sv - dino runner sequencer: FSM, jump physics, scroll, collision, score
module team_08_game_controller
  import team_08_game_controller_pkg::*;
#(
  parameter int         JUMP_V    = 12,
  parameter int         GRAVITY   = 1,
  parameter int         SPEED     = 2,
  parameter int         WIN_SCORE = 20,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       jump_btn,
  output state_t     state,
  output logic [7:0] dinoY,
  output logic [8:0] cactusX,
  output logic [8:0] x_dist,
  output logic [7:0] cactusH1,
  output logic [7:0] cactusH2,
  output logic [7:0] score
);

  state_t      state_q;
  geom_t       geom_q;
  geom_t       geom_d;
  logic        pend_q;
  logic        start_prev_q;
  logic        jump_prev_q;
  logic [7:0]  lfsr;

  logic        start_edge;
  logic        jump_edge;
  logic [7:0]  height;
  logic        launch;
  logic [7:0]  v_eff;
  logic signed [9:0] sum;
  logic [9:0]  x_adv;
  logic        respawn;
  logic [6:0]  new_dist;
  logic [9:0]  lead_x;
  logic        hit;

  team_08_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en_i (1'b1),
    .q_o  (lfsr)
  );

  assign start_edge = start_btn & ~start_prev_q;
  assign jump_edge  = jump_btn & ~jump_prev_q;

  // One frame of motion, computed entirely from the pre-tick register values.
  always_comb begin
    geom_d = geom_q;

    // Jump: a pending jump only launches from the ground; otherwise it is dropped.
    height = geom_q.dino_y - 8'(GROUND_Y);
    launch = pend_q && !geom_q.air;
    v_eff  = launch ? 8'(JUMP_V) : geom_q.vel;
    sum    = $signed({2'b00, height}) + $signed({{2{v_eff[7]}}, v_eff});
    if (geom_q.air || launch) begin
      if (sum <= 10'sd0) begin
        geom_d.dino_y = 8'(GROUND_Y);
        geom_d.vel    = 8'd0;
        geom_d.air    = 1'b0;
      end else begin
        geom_d.dino_y = 8'(GROUND_Y) + sum[7:0];
        geom_d.vel    = v_eff - 8'(GRAVITY);
        geom_d.air    = 1'b1;
      end
    end

    // Scroll, and recycle the lead cactus once it leaves the right edge.
    // The trailing cactus then becomes the lead at its scrolled x.
    x_adv    = {1'b0, geom_q.cactus_x} + 10'(SPEED);
    respawn  = (x_adv + {1'b0, geom_q.x_dist}) > 10'(X_END);
    new_dist = 7'd96 + {2'b00, lfsr[4:0]};
    if (respawn) begin
      geom_d.cactus_x = 9'(x_adv - {3'b000, new_dist});
      geom_d.x_dist   = {2'b00, new_dist};
      geom_d.h2       = geom_q.h1;
      geom_d.h1       = 8'd20 + {3'b000, lfsr[7:3]};
      geom_d.score    = (geom_q.score == 8'hFF) ? 8'hFF : geom_q.score + 8'd1;
    end else begin
      geom_d.cactus_x = x_adv[8:0];
    end
  end

  // Collision against both cacti on the pre-tick positions.
  always_comb begin
    lead_x = {1'b0, geom_q.cactus_x} + {1'b0, geom_q.x_dist};
    hit    = cactus_hit({1'b0, geom_q.cactus_x}, geom_q.h1, geom_q.dino_y) ||
             cactus_hit(lead_x, geom_q.h2, geom_q.dino_y);
  end

  // Game FSM; geometry only moves on a tick in RUN that does not collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      geom_q       <= GEOM_RST;
      pend_q       <= 1'b0;
      start_prev_q <= 1'b0;
      jump_prev_q  <= 1'b0;
    end else begin
      start_prev_q <= start_btn;
      jump_prev_q  <= jump_btn;
      if (jump_edge) begin
        pend_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (start_edge) begin
            state_q <= RUN;
            geom_q  <= GEOM_RST;
            pend_q  <= 1'b0;
          end
        end
        RUN: begin
          if (frame_tick) begin
            // An edge arriving with the tick is kept for the next frame.
            pend_q <= jump_edge;
            if (hit) begin
              state_q <= OVER;
            end else begin
              geom_q <= geom_d;
              if (geom_d.score == 8'(WIN_SCORE)) begin
                state_q <= WIN;
              end
            end
          end
        end
        default: begin
          if (start_edge) begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign state    = state_q;
  assign dinoY    = geom_q.dino_y;
  assign cactusX  = geom_q.cactus_x;
  assign x_dist   = geom_q.x_dist;
  assign cactusH1 = geom_q.h1;
  assign cactusH2 = geom_q.h2;
  assign score    = geom_q.score;

endmodule
